// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 type, special-value constants and NaN test
package fp16_pkg;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] man;
   } fp16_t;

   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [15:0] FP16_PINF    = 16'h7C00;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   function automatic logic is_nan(input fp16_t v);
      return (v.exp == FP16_EXP_MAX) && (v.man != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_stream_accum_add.sv
// add: combinational binary16 adder, round-to-nearest-even, subnormal aware
module add
   import fp16_pkg::*;
(
   input  logic [15:0] input_a,
   input  logic [15:0] input_b,
   output logic [15:0] add_out,
   output logic        add_valid
);

   fp16_t       w_a, w_b, w_x, w_y;
   logic        w_sub, w_st, w_rnd, w_sign;
   logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
   logic [4:0]  w_ex, w_ey, w_d;
   logic [13:0] w_mx, w_my, w_sh;
   logic [14:0] w_m;
   logic [5:0]  w_e;
   logic [11:0] w_mr;

   // align the smaller magnitude onto the larger, add/subtract, normalise, round
   always_comb begin
      w_a     = input_a;
      w_b     = input_b;
      w_nan_a = is_nan(w_a);
      w_nan_b = is_nan(w_b);
      w_inf_a = (w_a.exp == FP16_EXP_MAX) && (w_a.man == 10'd0);
      w_inf_b = (w_b.exp == FP16_EXP_MAX) && (w_b.man == 10'd0);
      w_x     = ({w_b.exp, w_b.man} > {w_a.exp, w_a.man}) ? w_b : w_a;
      w_y     = ({w_b.exp, w_b.man} > {w_a.exp, w_a.man}) ? w_a : w_b;
      w_sub   = w_x.sign ^ w_y.sign;
      w_ex    = (w_x.exp == 5'd0) ? 5'd1 : w_x.exp;
      w_ey    = (w_y.exp == 5'd0) ? 5'd1 : w_y.exp;
      w_mx    = {(w_x.exp != 5'd0), w_x.man, 3'b000};
      w_my    = {(w_y.exp != 5'd0), w_y.man, 3'b000};
      w_d     = w_ex - w_ey;
      w_sh    = w_my >> w_d;
      w_st    = ((w_sh << w_d) != w_my);
      w_m     = w_sub ? ({1'b0, w_mx} - {1'b0, w_sh[13:1], w_sh[0] | w_st})
                      : ({1'b0, w_mx} + {1'b0, w_sh[13:1], w_sh[0] | w_st});
      w_sign  = (w_sub && (w_m == 15'd0)) ? 1'b0 : w_x.sign;
      w_e     = {1'b0, w_ex};
      if (w_m[14]) begin
         w_m = {1'b0, w_m[14:2], w_m[1] | w_m[0]};
         w_e = w_e + 6'd1;
      end
      for (int i = 0; i < 13; i++)
         if (!w_m[13] && (w_e > 6'd1)) begin
            w_m = w_m << 1;
            w_e = w_e - 6'd1;
         end
      w_rnd = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
      w_mr  = {1'b0, w_m[13:3]} + {11'd0, w_rnd};
      if (w_mr[11]) begin
         w_mr = w_mr >> 1;
         w_e  = w_e + 6'd1;
      end
      add_valid = 1'b1;
      add_out   = (w_e >= 6'd31) ? {w_sign, FP16_PINF[14:0]}
                                 : {w_sign, (w_mr[10] ? w_e[4:0] : 5'd0), w_mr[9:0]};
      if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_a.sign != w_b.sign))) begin
         add_out   = FP16_QNAN;
         add_valid = 1'b0;
      end else if (w_inf_a)
         add_out = input_a;
      else if (w_inf_b)
         add_out = input_b;
   end

endmodule

// File: rtl/fp16_stream_accum.sv
// fp16_stream_accum: sums fp16 packets from a valid/ready stream into one result per packet
module fp16_stream_accum
   import fp16_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             out_nan,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} accum_state_e;

   accum_state_e     r_state, w_state_n;
   logic [15:0]      r_acc, w_acc_n, w_add_out;
   logic             r_nan, w_nan_n, r_sat, w_sat_n;
   logic             w_add_valid, w_fire, w_first;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;

   add u_add (
      .input_a   (r_acc),
      .input_b   (in_data),
      .add_out   (w_add_out),
      .add_valid (w_add_valid)
   );

   // handshake, next state, and the packet state a fire would produce
   always_comb begin
      in_ready  = (r_state != DONE) || out_ready;
      out_valid = (r_state == DONE);
      w_fire    = in_valid && in_ready;
      w_first   = (r_state != ACC);
      w_state_n = r_state;
      if (w_fire)
         w_state_n = in_last ? DONE : ACC;
      else if ((r_state == DONE) && out_ready)
         w_state_n = IDLE;
      w_acc_n = w_first ? in_data : w_add_out;
      w_nan_n = w_first ? is_nan(in_data) : (r_nan | is_nan(in_data) | ~w_add_valid);
      w_cnt_n = w_first ? CNT_W'(1) : ((r_cnt < CNT_W'(MAX_LEN)) ? r_cnt + 1'b1 : r_cnt);
      w_sat_n = w_first ? 1'b0 : (r_sat | (r_cnt == CNT_W'(MAX_LEN)));
   end

   // state register; packet registers on every fire, result registers on the last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_nan     <= 1'b0;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
         out_data  <= '0;
         out_nan   <= 1'b0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_fire) begin
            r_acc <= w_acc_n;
            r_nan <= w_nan_n;
            r_cnt <= w_cnt_n;
            r_sat <= w_sat_n;
         end
         if (w_fire && in_last) begin
            out_data  <= w_nan_n ? FP16_QNAN : w_acc_n;
            out_nan   <= w_nan_n;
            out_count <= w_cnt_n;
            out_sat   <= w_sat_n;
         end
      end
   end

endmodule

// File: tb/tb_fp16_stream_accum.sv
// tb_fp16_stream_accum: directed packets checked against a queue of expected results
module tb_fp16_stream_accum;

   localparam int MAX_LEN = 4;
   localparam int CNT_W   = 3;

   typedef struct packed {
      logic [15:0]      data;
      logic             nan;
      logic [CNT_W-1:0] count;
      logic             sat;
   } exp_t;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [15:0]      in_data = 16'd0;
   logic             in_ready, out_valid, out_nan, out_sat;
   logic [15:0]      out_data;
   logic [CNT_W-1:0] out_count;
   exp_t             q[$];
   exp_t             e;
   int               checks = 0, errors = 0;
   int               w;

   always #5 clk = ~clk;

   fp16_stream_accum #(.MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_nan   (out_nan),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_res(input logic [15:0] d, input logic n, input int c, input logic s);
      q.push_back('{data: d, nan: n, count: CNT_W'(c), sat: s});
   endtask

   task automatic send(input logic [15:0] d, input logic l, output int waited);
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("send_timeout", {15'd0, waited < 50}, 16'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // scoreboard: every retired result must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0)
            chk("spurious_result", {15'd0, out_valid}, 16'd0);
         else begin
            e = q.pop_front();
            chk("res_data", out_data, e.data);
            chk("res_nan", {15'd0, out_nan}, {15'd0, e.nan});
            chk("res_count", {13'd0, out_count}, {13'd0, e.count});
            chk("res_sat", {15'd0, out_sat}, {15'd0, e.sat});
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_data", out_data, 16'd0);
      chk("rst_count", {13'd0, out_count}, 16'd0);
      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_res(16'h4300, 1'b0, 3, 1'b0);
      send(16'h3C00, 1'b0, w);
      send(16'h4000, 1'b0, w);
      send(16'h3800, 1'b1, w);
      chk("a_latency", {15'd0, out_valid}, 16'd1);
      expect_res(16'h4000, 1'b0, 1, 1'b0);
      send(16'h4000, 1'b1, w);
      chk("single_valid", {15'd0, out_valid}, 16'd1);
      expect_res(16'h7E00, 1'b1, 3, 1'b0);
      send(16'h3C00, 1'b0, w);
      chk("no_bubble_wait", 16'(w), 16'd0);
      chk("no_bubble_retired", {15'd0, out_valid}, 16'd0);
      send(16'h7E01, 1'b0, w);
      send(16'h4000, 1'b1, w);
      expect_res(16'h7C00, 1'b0, 2, 1'b0);
      send(16'h7BFF, 1'b0, w);
      send(16'h7BFF, 1'b1, w);
      expect_res(16'h4400, 1'b0, 2, 1'b0);
      send(16'h4000, 1'b0, w);
      out_ready = 1'b0;
      send(16'h4000, 1'b1, w);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", {15'd0, out_valid}, 16'd1);
         chk("bp_data", out_data, 16'h4400);
         chk("bp_count", {13'd0, out_count}, 16'd2);
         chk("bp_nan", {15'd0, out_nan}, 16'd0);
         chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      end
      @(posedge clk);
      #1;
      expect_res(16'h4600, 1'b0, 4, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h3C00;
      in_last   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_retire_accept", {15'd0, out_valid}, 16'd0);
      repeat (4) send(16'h3C00, 1'b0, w);
      send(16'h3C00, 1'b1, w);
      chk("sat_valid", {15'd0, out_valid}, 16'd1);
      @(posedge clk);
      #1;
      send(16'h3C00, 1'b0, w);
      send(16'h4000, 1'b0, w);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_data", out_data, 16'd0);
      chk("mid_rst_count", {13'd0, out_count}, 16'd0);
      chk("mid_rst_sat", {15'd0, out_sat}, 16'd0);
      chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_res(16'h3C00, 1'b0, 1, 1'b0);
      send(16'h3C00, 1'b1, w);
      chk("post_rst_valid", {15'd0, out_valid}, 16'd1);
      w = 0;
      while (q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("drain", 16'(q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
